// File: rtl/nbody_pkg.sv
// nbody_pkg: shared constants for the n-body tile scheduler.
//   - Default MAX_BLOCKS / ARRAY_LAT values used by nbody_tile_scheduler.
//   - FSM state encodings, as plain localparams.
//   - Tile tag layout {valid, i, j, diag}, MSB first, and a helper that sizes it.
package nbody_pkg;

  localparam int unsigned DEF_MAX_BLOCKS = 8;
  localparam int unsigned DEF_ARRAY_LAT  = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CLEAR     = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_DRAIN     = 3'd3;
  localparam logic [2:0] ST_INTEGRATE = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  // Tag layout for the default configuration; wider builds use the same field order.
  typedef struct packed {
    logic                              valid;
    logic [$clog2(DEF_MAX_BLOCKS)-1:0] i;
    logic [$clog2(DEF_MAX_BLOCKS)-1:0] j;
    logic                              diag;
  } tag_t;

  function automatic int unsigned tag_width(int unsigned max_blocks);
    return 2 * $clog2(max_blocks) + 2;
  endfunction

endpackage

// File: rtl/nbody_tile_scheduler_tag_pipe.sv
// nbody_tag_pipe: DEPTH-stage shift register of tile tags, valid bit in the MSB.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   flush     synchronous clear of every stage
//   din       tag entering stage 0 each cycle
//   dout      tag leaving the last stage (DEPTH cycles after entry)
//   pending   a valid tag sits in any stage other than the last
module nbody_tag_pipe #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pending
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) stage[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < int'(DEPTH); k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[DEPTH-1];

  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < int'(DEPTH) - 1; k++) pending = pending | stage[k][WIDTH-1];
  end

endmodule

// File: rtl/nbody_tile_scheduler.sv
// nbody_tile_scheduler: sequences tile issue, accumulate-write tagging and integrator
// streaming for the 2x2 systolic n-body array, repeated for n_steps time steps.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, abort                 host launch pulse (IDLE only) / synchronous abort
//   n_blocks, n_steps            run configuration, latched at start
//   busy, done, step_cnt         host status
//   acc_clr                      accumulator clear, once per step
//   arr_issue, arr_blk_i/j, arr_diag      tile launch to the array
//   acc_we, acc_blk_i/j, acc_down_en      retiring tile to the accumulators
//   int_valid, int_body, int_ready        integrator body stream
// Build option: NBODY_SCHED_FULL_MATRIX_EN issues all nb^2 tiles with right-only
// accumulation; default issues the upper triangle and uses down accumulation.
module nbody_tile_scheduler
  import nbody_pkg::*;
#(
  parameter int unsigned MAX_BLOCKS = DEF_MAX_BLOCKS,
  parameter int unsigned ARRAY_LAT  = DEF_ARRAY_LAT,
  parameter int unsigned STEP_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [$clog2(MAX_BLOCKS+1)-1:0]   n_blocks,
  input  logic [STEP_W-1:0]                 n_steps,
  output logic                              busy,
  output logic                              done,
  output logic [STEP_W-1:0]                 step_cnt,
  output logic                              acc_clr,
  output logic                              arr_issue,
  output logic [$clog2(MAX_BLOCKS)-1:0]     arr_blk_i,
  output logic [$clog2(MAX_BLOCKS)-1:0]     arr_blk_j,
  output logic                              arr_diag,
  output logic                              acc_we,
  output logic [$clog2(MAX_BLOCKS)-1:0]     acc_blk_i,
  output logic [$clog2(MAX_BLOCKS)-1:0]     acc_blk_j,
  output logic                              acc_down_en,
  output logic                              int_valid,
  output logic [$clog2(2*MAX_BLOCKS)-1:0]   int_body,
  input  logic                              int_ready
);

  localparam int unsigned NB_W   = $clog2(MAX_BLOCKS + 1);
  localparam int unsigned IDX_W  = $clog2(MAX_BLOCKS);
  localparam int unsigned BODY_W = $clog2(2 * MAX_BLOCKS);
  localparam int unsigned TAG_W  = tag_width(MAX_BLOCKS);

  logic [2:0]        state_q, state_d;
  logic [NB_W-1:0]   nb_q, nb_d, nb_in;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              empty_q, empty_d;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
  logic [BODY_W-1:0] body_q, body_d;

  logic              i_last, j_last, body_last;
  logic [NB_W:0]     body_last_idx;
  logic [TAG_W-1:0]  tag_in, tag_out;
  logic              tag_pending;

  assign nb_in         = (n_blocks > NB_W'(MAX_BLOCKS)) ? NB_W'(MAX_BLOCKS) : n_blocks;
  assign i_last        = (NB_W'(i_q) == nb_q - 1'b1);
  assign j_last        = (NB_W'(j_q) == nb_q - 1'b1);
  assign body_last_idx = {nb_q, 1'b0} - 1'b1;
  assign body_last     = ((NB_W+1)'(body_q) == body_last_idx);

  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    steps_d    = steps_q;
    empty_d    = empty_q;
    step_cnt_d = step_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    body_d     = body_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            nb_d       = nb_in;
            steps_d    = n_steps;
            empty_d    = (nb_in == '0) || (n_steps == '0);
            step_cnt_d = '0;
            state_d    = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // An empty run passes through here silently so done lands two cycles after start.
          i_d     = '0;
          j_d     = '0;
          body_d  = '0;
          state_d = empty_q ? ST_FINISH : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (i_last && j_last) begin
            state_d = ST_DRAIN;
          end else if (j_last) begin
            i_d = i_q + 1'b1;
`ifdef NBODY_SCHED_FULL_MATRIX_EN
            j_d = '0;
`else
            j_d = i_q + 1'b1;
`endif
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Leave once only the final tag (if any) remains, so INTEGRATE follows the last acc_we.
          if (!tag_pending) state_d = ST_INTEGRATE;
        end
        ST_INTEGRATE: begin
          if (int_ready) begin
            if (body_last) begin
              step_cnt_d = step_cnt_q + 1'b1;
              state_d    = (step_cnt_d == steps_q) ? ST_FINISH : ST_CLEAR;
            end else begin
              body_d = body_q + 1'b1;
            end
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nb_q       <= '0;
      steps_q    <= '0;
      empty_q    <= 1'b0;
      step_cnt_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      body_q     <= '0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      steps_q    <= steps_d;
      empty_q    <= empty_d;
      step_cnt_q <= step_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      body_q     <= body_d;
    end
  end

  always_comb begin
    busy      = (state_q == ST_CLEAR) || (state_q == ST_ISSUE) ||
                (state_q == ST_DRAIN) || (state_q == ST_INTEGRATE);
    done      = (state_q == ST_FINISH);
    acc_clr   = (state_q == ST_CLEAR) && !empty_q;
    arr_issue = (state_q == ST_ISSUE);
    arr_blk_i = arr_issue ? i_q : '0;
    arr_blk_j = arr_issue ? j_q : '0;
    arr_diag  = arr_issue && (i_q == j_q);
    int_valid = (state_q == ST_INTEGRATE);
    int_body  = int_valid ? body_q : '0;
    step_cnt  = step_cnt_q;
  end

  assign tag_in = {arr_issue, arr_blk_i, arr_blk_j, arr_diag};

  nbody_tag_pipe #(
    .DEPTH (ARRAY_LAT),
    .WIDTH (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .din     (tag_in),
    .dout    (tag_out),
    .pending (tag_pending)
  );

  assign acc_we    = tag_out[TAG_W-1];
  assign acc_blk_i = tag_out[2*IDX_W:IDX_W+1];
  assign acc_blk_j = tag_out[IDX_W:1];
`ifdef NBODY_SCHED_FULL_MATRIX_EN
  assign acc_down_en = 1'b0;
`else
  assign acc_down_en = acc_we && !tag_out[0];
`endif

endmodule

// File: tb/tb_nbody_tile_scheduler.sv
// Directed self-checking bench for nbody_tile_scheduler (MAX_BLOCKS=8, ARRAY_LAT=4).
module tb_nbody_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, abort, int_ready;
  logic [3:0]  n_blocks;
  logic [15:0] n_steps;
  logic        busy, done, acc_clr, arr_issue, arr_diag, acc_we, acc_down_en, int_valid;
  logic [15:0] step_cnt;
  logic [2:0]  arr_blk_i, arr_blk_j, acc_blk_i, acc_blk_j;
  logic [3:0]  int_body;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nbody_tile_scheduler #(
    .MAX_BLOCKS (8),
    .ARRAY_LAT  (4),
    .STEP_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .n_blocks    (n_blocks),
    .n_steps     (n_steps),
    .busy        (busy),
    .done        (done),
    .step_cnt    (step_cnt),
    .acc_clr     (acc_clr),
    .arr_issue   (arr_issue),
    .arr_blk_i   (arr_blk_i),
    .arr_blk_j   (arr_blk_j),
    .arr_diag    (arr_diag),
    .acc_we      (acc_we),
    .acc_blk_i   (acc_blk_i),
    .acc_blk_j   (acc_blk_j),
    .acc_down_en (acc_down_en),
    .int_valid   (int_valid),
    .int_body    (int_body),
    .int_ready   (int_ready)
  );

  // {busy,done,acc_clr,arr_issue,arr_blk_i,arr_blk_j,arr_diag,acc_we,acc_blk_i,acc_blk_j,
  //  acc_down_en,int_valid,int_body}
  wire [23:0] obs = {busy, done, acc_clr, arr_issue, arr_blk_i, arr_blk_j, arr_diag, acc_we,
                     acc_blk_i, acc_blk_j, acc_down_en, int_valid, int_body};

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; int_ready = 1'b1;
    n_blocks = '0; n_steps = '0;
    #1;
    tests++;
    if (obs !== 24'h0 || step_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%h expected 000000/0000", obs, step_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (obs !== 24'h0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h expected 000000", obs);
    end
  endtask

  // nb=2, steps=1: exact cycle-by-cycle trace relative to the start cycle t.
  task automatic test_nb2_trace();
    logic [23:0] e;
    logic [2:0]  ti, tj;
    n_blocks = 4'd2; n_steps = 16'd1; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      e = '0;
      e[23] = (c <= 12);
      e[22] = (c == 13);
      e[21] = (c == 1);
      if (c >= 2 && c <= 4) begin
        ti = (c == 4) ? 3'd1 : 3'd0;
        tj = (c == 2) ? 3'd0 : 3'd1;
        e[20] = 1'b1; e[19:17] = ti; e[16:14] = tj; e[13] = (ti == tj);
      end
      if (c >= 6 && c <= 8) begin
        ti = (c == 8) ? 3'd1 : 3'd0;
        tj = (c == 6) ? 3'd0 : 3'd1;
        e[12] = 1'b1; e[11:9] = ti; e[8:6] = tj; e[5] = (ti != tj);
      end
      if (c >= 9 && c <= 12) begin
        e[4] = 1'b1; e[3:0] = 4'(c - 9);
      end
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL nb2_trace t+%0d: got %h expected %h", c, obs, e);
      end
      if (c == 13) begin
        tests++;
        if (step_cnt !== 16'd1) begin
          fails++;
          $display("FAIL nb2_step_cnt: got %0d expected 1", step_cnt);
        end
      end
    end
  endtask

  // Full-matrix build, nb=2: four tiles row-major, no down accumulation.
  task automatic test_full_matrix();
    logic [23:0] e;
    logic [2:0]  ti, tj;
    n_blocks = 4'd2; n_steps = 16'd1; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      e = '0;
      e[23] = (c <= 13);
      e[22] = (c == 14);
      e[21] = (c == 1);
      if (c >= 2 && c <= 5) begin
        ti = 3'((c - 2) / 2); tj = 3'((c - 2) % 2);
        e[20] = 1'b1; e[19:17] = ti; e[16:14] = tj; e[13] = (ti == tj);
      end
      if (c >= 6 && c <= 9) begin
        ti = 3'((c - 6) / 2); tj = 3'((c - 6) % 2);
        e[12] = 1'b1; e[11:9] = ti; e[8:6] = tj;
      end
      if (c >= 10 && c <= 13) begin
        e[4] = 1'b1; e[3:0] = 4'(c - 10);
      end
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL full_trace t+%0d: got %h expected %h", c, obs, e);
      end
    end
  endtask

  // nb=3, steps=2 (upper-triangular): 6 tiles per step in row-major order.
  task automatic test_nb3_two_steps();
    int ei[6] = '{0, 0, 0, 1, 1, 2};
    int ej[6] = '{0, 1, 2, 1, 2, 2};
    int n_iss = 0, n_clr = 0, n_done = 0, n_we = 0, n_down = 0, n_beats = 0, bad_order = 0;
    n_blocks = 4'd3; n_steps = 16'd2; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 200 && n_done == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (acc_clr) begin
        n_clr++;
        if (n_clr == 2) begin
          tests++;
          if (step_cnt !== 16'd1) begin
            fails++;
            $display("FAIL nb3_step_cnt_mid: got %0d expected 1", step_cnt);
          end
        end
      end
      if (arr_issue) begin
        if (arr_blk_i !== 3'(ei[n_iss % 6]) || arr_blk_j !== 3'(ej[n_iss % 6])) bad_order++;
        n_iss++;
      end
      if (acc_we) n_we++;
      if (acc_down_en) n_down++;
      if (int_valid) n_beats++;
      if (done) begin
        n_done++;
        tests++;
        if (step_cnt !== 16'd2) begin
          fails++;
          $display("FAIL nb3_step_cnt_end: got %0d expected 2", step_cnt);
        end
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    tests++;
    if (n_iss != 12 || n_clr != 2 || n_done != 1) begin
      fails++;
      $display("FAIL nb3_counts: issues %0d clr %0d done %0d expected 12 2 1", n_iss, n_clr,
               n_done);
    end
    tests++;
    if (n_we != 12 || n_down != 6 || n_beats != 12) begin
      fails++;
      $display("FAIL nb3_acc: we %0d down %0d beats %0d expected 12 6 12", n_we, n_down,
               n_beats);
    end
    tests++;
    if (bad_order != 0) begin
      fails++;
      $display("FAIL nb3_order: %0d out-of-order tiles expected 0", bad_order);
    end
  endtask

  // nb=2: int_ready 1,0,0,1,1,1 over the integrate cycles; body must hold while stalled.
  task automatic test_int_stall();
    logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   exp_body[6] = '{0, 1, 1, 1, 2, 3};
    int   idx = 0, last_iv = -10, done_c = -1;
    n_blocks = 4'd2; n_steps = 16'd1; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (int_valid) begin
        int_ready = (idx < 6) ? pat[idx] : 1'b1;
        if (idx < 6) begin
          tests++;
          if (int_body !== 4'(exp_body[idx])) begin
            fails++;
            $display("FAIL stall_body beat %0d: got %0d expected %0d", idx, int_body,
                     exp_body[idx]);
          end
        end
        idx++;
        last_iv = c;
      end
      if (done) done_c = c;
    end
    int_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (idx != 6 || done_c != last_iv + 1) begin
      fails++;
      $display("FAIL stall_done: valid cycles %0d done gap %0d expected 6 1", idx,
               done_c - last_iv);
    end
  endtask

  // n_blocks=0 or n_steps=0: busy one cycle, done at t+2, nothing else.
  task automatic test_zero_run(input logic [3:0] nb, input logic [15:0] ns);
    logic [23:0] e;
    n_blocks = nb; n_steps = ns; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      e = '0;
      e[23] = (c == 1);
      e[22] = (c == 2);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL zero_run nb=%0d ns=%0d t+%0d: got %h expected %h", nb, ns, c, obs, e);
      end
    end
  endtask

  // Abort during the second step's DRAIN, then a fresh nb=1 run.
  task automatic test_abort();
`ifdef NBODY_SCHED_FULL_MATRIX_EN
    int abort_c = 19;
`else
    int abort_c = 18;
`endif
    int done_c = -1, n_done = 0;
    n_blocks = 4'd2; n_steps = 16'd2; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= abort_c; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests++;
    if (acc_we !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: acc_we %b busy %b expected 1 1", acc_we, busy);
    end
    abort = 1'b1;
    for (int c = abort_c + 1; c <= abort_c + 12; c++) begin
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (obs !== 24'h0 || step_cnt !== 16'd1) begin
        fails++;
        $display("FAIL abort_quiet t+%0d: got %h/%0d expected 000000/1", c, obs, step_cnt);
      end
    end
    n_blocks = 4'd1; n_steps = 16'd1; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        n_done++;
        done_c = c;
      end
    end
    tests++;
    if (done_c != 9 || n_done != 1) begin
      fails++;
      $display("FAIL abort_restart: done at t+%0d count %0d expected t+9 1", done_c, n_done);
    end
  endtask

  // Asynchronous reset in the middle of the second step's ISSUE.
  task automatic test_async_reset();
    int n_clr = 0;
    n_blocks = 4'd3; n_steps = 16'd2; int_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 100 && n_clr < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (acc_clr) n_clr++;
    end
    @(negedge clk);
    tests++;
    if (arr_issue !== 1'b1 || step_cnt !== 16'd1) begin
      fails++;
      $display("FAIL rst_pre: arr_issue %b step_cnt %0d expected 1 1", arr_issue, step_cnt);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs !== 24'h0 || step_cnt !== 16'h0) begin
      fails++;
      $display("FAIL rst_async: got %h/%0d expected 000000/0", obs, step_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (obs !== 24'h0) begin
      fails++;
      $display("FAIL rst_after: got %h expected 000000", obs);
    end
  endtask

  initial begin
    test_reset();
`ifdef NBODY_SCHED_FULL_MATRIX_EN
    test_full_matrix();
`else
    test_nb2_trace();
    test_nb3_two_steps();
`endif
    test_int_stall();
    test_zero_run(4'd0, 16'd3);
    test_zero_run(4'd2, 16'd0);
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
